// File: rtl/tnn_seq_pkg.sv
// Shared types and constants for the TNN node sequencer.
// Optional feature macro used elsewhere: TNN_SEQ_PERF_EN.
package tnn_seq_pkg;

    localparam int NFEAT = 11;
    localparam int FW    = 3;
    localparam int NOPND = 6;
    localparam int NNODE = 8;
    localparam int THR   = 4;

    localparam int IW = $clog2(NFEAT);
    localparam int NW = $clog2(NNODE);
    localparam int SW = $clog2(NOPND);
    localparam int VW = $clog2(NNODE + 1);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    // Reset routing is identical for every node: slot s reads feature s.
    function automatic logic [IW-1:0] init_sel(input int node, input int slot);
        init_sel = IW'((slot + node * 0) % NFEAT);
    endfunction

endpackage

// File: rtl/tnn_opnd_mux.sv
// Routes features of the held sample onto the shared core operands
// according to one selection-table row.
module tnn_opnd_mux
    import tnn_seq_pkg::*;
(
    input  logic                en,
    input  logic [NFEAT*FW-1:0] sample,
    input  logic [IW-1:0]       row [NOPND],
    output logic [NOPND*FW-1:0] opnd
);

    int idx;

    always_comb begin
        opnd = '0;
        idx  = 0;
        for (int s = 0; s < NOPND; s++) begin
            idx = int'(row[s]);
            // Out-of-range selections route a zero operand.
            if (en && idx < NFEAT) begin
                opnd[s*FW +: FW] = sample[idx*FW +: FW];
            end
        end
    end

endmodule

// File: rtl/tnn_node_sequencer.sv
// Time-multiplexes one TNN comparator core over NNODE nodes per sample.
// Define TNN_SEQ_PERF_EN to add perf_samples/perf_ones counters.
module tnn_node_sequencer
    import tnn_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NFEAT*FW-1:0] in_feat,
    output logic [NOPND*FW-1:0] core_opnd,
    input  logic                core_res,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_class,
    output logic [VW-1:0]       out_votes,
    input  logic                cfg_we,
    input  logic [NW-1:0]       cfg_node,
    input  logic [SW-1:0]       cfg_slot,
    input  logic [IW-1:0]       cfg_idx,
    output logic                cfg_err
`ifdef TNN_SEQ_PERF_EN
    ,
    output logic [31:0]         perf_samples,
    output logic [31:0]         perf_ones
`endif
);

    state_t state, state_nx;

    logic [NW-1:0]       node;
    logic [VW-1:0]       votes;
    logic [NFEAT*FW-1:0] sample;
    logic [IW-1:0]       tbl [NNODE][NOPND];

    logic          pend_v;
    logic [NW-1:0] pend_node;
    logic [SW-1:0] pend_slot;
    logic [IW-1:0] pend_idx;

    logic in_fire;
    logic out_fire;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_votes = votes;
    assign out_class = (votes >= VW'(THR));

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = EVAL;
            end
            EVAL: begin
                if (node == NW'(NNODE - 1)) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            node      <= '0;
            votes     <= '0;
            sample    <= '0;
            cfg_err   <= 1'b0;
            pend_v    <= 1'b0;
            pend_node <= '0;
            pend_slot <= '0;
            pend_idx  <= '0;
            for (int n = 0; n < NNODE; n++) begin
                for (int s = 0; s < NOPND; s++) begin
                    tbl[n][s] <= init_sel(n, s);
                end
            end
        end else begin
            state   <= state_nx;
            cfg_err <= cfg_we && (state != IDLE);
            if (in_fire) begin
                sample <= in_feat;
                votes  <= '0;
                node   <= '0;
            end
            if (state == EVAL) begin
                node <= node + 1'b1;
                if (core_res && votes < VW'(NNODE)) votes <= votes + 1'b1;
            end
            // A write landing with in_fire is held back so the sample
            // in flight keeps the routing it was accepted with.
            if (cfg_we && state == IDLE) begin
                if (in_fire) begin
                    pend_v    <= 1'b1;
                    pend_node <= cfg_node;
                    pend_slot <= cfg_slot;
                    pend_idx  <= cfg_idx;
                end else begin
                    tbl[cfg_node][cfg_slot] <= cfg_idx;
                end
            end
            if (out_fire && pend_v) begin
                tbl[pend_node][pend_slot] <= pend_idx;
                pend_v <= 1'b0;
            end
        end
    end

    tnn_opnd_mux u_mux (
        .en     (state == EVAL),
        .sample (sample),
        .row    (tbl[node]),
        .opnd   (core_opnd)
    );

`ifdef TNN_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_samples <= '0;
            perf_ones    <= '0;
        end else if (out_fire) begin
            perf_samples <= perf_samples + 32'd1;
            if (out_class) perf_ones <= perf_ones + 32'd1;
        end
    end
`endif

endmodule
